// File: rtl/axis_frame_source_if.sv
// Command and AXI-stream bundle for the frame source: command handshake in, frame beats out.
// master = the frame source itself, slave = whatever feeds commands and sinks beats.
interface axis_frame_source_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [LEN_WIDTH-1:0]  cmd_len;
   logic [DATA_WIDTH-1:0] cmd_seed;
   logic                  cmd_bad;
   logic [DATA_WIDTH-1:0] output_axis_tdata;
   logic                  output_axis_tvalid;
   logic                  output_axis_tready;
   logic                  output_axis_tlast;
   logic                  output_axis_tuser;

   modport master (
      input  cmd_valid, cmd_len, cmd_seed, cmd_bad, output_axis_tready,
      output cmd_ready, output_axis_tdata, output_axis_tvalid,
             output_axis_tlast, output_axis_tuser
   );

   modport slave (
      output cmd_valid, cmd_len, cmd_seed, cmd_bad, output_axis_tready,
      input  cmd_ready, output_axis_tdata, output_axis_tvalid,
             output_axis_tlast, output_axis_tuser
   );
endinterface

// File: rtl/axis_frame_source.sv
// Command-driven AXI-stream frame generator; 1-cycle command-to-first-beat latency, one beat/cycle.
// tready=0 freezes all stream outputs; cmd_ready is the only combinational output (IDLE or last beat leaving).
module axis_frame_source #(
   parameter int DATA_WIDTH = 8,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   axis_frame_source_if.master    io_axis,
   output logic                   busy,
   output logic [15:0]            frame_count
);
   typedef enum logic {IDLE, SEND} state_t;

   state_t                r_state,  w_state_nxt;
   logic [LEN_WIDTH-1:0]  r_len,    w_len_nxt;
   logic [LEN_WIDTH-1:0]  r_cnt,    w_cnt_nxt;
   logic [DATA_WIDTH-1:0] r_data,   w_data_nxt;
   logic                  r_bad,    w_bad_nxt;
   logic                  r_tvalid, w_tvalid_nxt;
   logic                  r_tlast,  w_tlast_nxt;
   logic                  r_tuser,  w_tuser_nxt;
   logic [15:0]           r_frame_count;

   logic                  w_beat_done;
   logic                  w_last_done;
   logic                  w_cmd_rdy;
   logic                  w_cmd_take;
   logic [LEN_WIDTH-1:0]  w_cnt_inc;
   logic                  w_next_is_last;

   assign w_beat_done    = r_tvalid & io_axis.output_axis_tready;
   assign w_last_done    = w_beat_done & r_tlast;
   assign w_cmd_rdy      = (r_state == IDLE) | w_last_done;
   assign w_cmd_take     = io_axis.cmd_valid & w_cmd_rdy;
   assign w_cnt_inc      = r_cnt + 1'b1;
   // Counter never passes r_len before tlast, so the increment cannot wrap here.
   assign w_next_is_last = (w_cnt_inc == r_len);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_len         <= '0;
         r_cnt         <= '0;
         r_data        <= '0;
         r_bad         <= 1'b0;
         r_tvalid      <= 1'b0;
         r_tlast       <= 1'b0;
         r_tuser       <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_len    <= w_len_nxt;
         r_cnt    <= w_cnt_nxt;
         r_data   <= w_data_nxt;
         r_bad    <= w_bad_nxt;
         r_tvalid <= w_tvalid_nxt;
         r_tlast  <= w_tlast_nxt;
         r_tuser  <= w_tuser_nxt;
         if (w_last_done) begin
            r_frame_count <= r_frame_count + 16'd1;
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_len_nxt    = r_len;
      w_cnt_nxt    = r_cnt;
      w_data_nxt   = r_data;
      w_bad_nxt    = r_bad;
      w_tvalid_nxt = r_tvalid;
      w_tlast_nxt  = r_tlast;
      w_tuser_nxt  = r_tuser;

      case (r_state)
         IDLE: begin
            if (w_cmd_take) begin
               w_state_nxt  = SEND;
               w_len_nxt    = io_axis.cmd_len;
               w_bad_nxt    = io_axis.cmd_bad;
               w_cnt_nxt    = '0;
               w_data_nxt   = io_axis.cmd_seed;
               w_tvalid_nxt = 1'b1;
               w_tlast_nxt  = (io_axis.cmd_len == '0);
               w_tuser_nxt  = io_axis.cmd_bad & (io_axis.cmd_len == '0);
            end
         end
         SEND: begin
            if (w_cmd_take) begin
               // Back-to-back: the next frame's beat 0 replaces the outgoing last beat.
               w_state_nxt  = SEND;
               w_len_nxt    = io_axis.cmd_len;
               w_bad_nxt    = io_axis.cmd_bad;
               w_cnt_nxt    = '0;
               w_data_nxt   = io_axis.cmd_seed;
               w_tvalid_nxt = 1'b1;
               w_tlast_nxt  = (io_axis.cmd_len == '0);
               w_tuser_nxt  = io_axis.cmd_bad & (io_axis.cmd_len == '0);
            end else if (w_last_done) begin
               w_state_nxt  = IDLE;
               w_tvalid_nxt = 1'b0;
               w_tlast_nxt  = 1'b0;
               w_tuser_nxt  = 1'b0;
            end else if (w_beat_done) begin
               w_cnt_nxt    = w_cnt_inc;
               w_data_nxt   = r_data + 1'b1;
               w_tlast_nxt  = w_next_is_last;
               w_tuser_nxt  = r_bad & w_next_is_last;
            end
         end
         default: begin
            w_state_nxt  = IDLE;
            w_tvalid_nxt = 1'b0;
            w_tlast_nxt  = 1'b0;
            w_tuser_nxt  = 1'b0;
         end
      endcase
   end

   assign io_axis.cmd_ready          = w_cmd_rdy;
   assign io_axis.output_axis_tdata  = r_data;
   assign io_axis.output_axis_tvalid = r_tvalid;
   assign io_axis.output_axis_tlast  = r_tlast;
   assign io_axis.output_axis_tuser  = r_tuser;
   assign busy                       = (r_state == SEND);
   assign frame_count                = r_frame_count;
endmodule

// File: tb/tb_axis_frame_source.sv
// Bench for axis_frame_source: directed scenarios plus random commands/backpressure,
// every beat and status output compared each cycle against a queue of expected beats.
module tb_axis_frame_source;
   localparam int DW = 8;
   localparam int LW = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   axis_frame_source_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   axis_frame_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk         (clk),
      .rst         (rst),
      .io_axis     (bus),
      .busy        (busy),
      .frame_count (frame_count)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct packed {
      logic [DW-1:0] d;
      logic          l;
      logic          u;
   } beat_t;

   beat_t exp_q[$];
   bit    in_frame = 1'b0;
   int    exp_fc   = 0;

   // Reference model: each accepted command expands into its list of beats;
   // beats leave the front of the list whenever downstream is ready during a frame.
   always @(negedge clk) begin
      beat_t         b;
      logic [DW-1:0] d;
      logic          exp_rdy;
      if (rst) begin
         exp_q.delete();
         in_frame = 1'b0;
         exp_fc   = 0;
      end else begin
         exp_rdy = !in_frame ||
                   (bus.output_axis_tready && exp_q.size() > 0 && exp_q[0].l);
         chk("busy", busy, in_frame);
         chk("tvalid", bus.output_axis_tvalid, in_frame);
         chk("frame_count", frame_count, exp_fc[15:0]);
         chk("cmd_ready", bus.cmd_ready, exp_rdy);
         if (bus.output_axis_tvalid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 1, 0);
            end else begin
               chk("tdata", bus.output_axis_tdata, exp_q[0].d);
               chk("tlast", bus.output_axis_tlast, exp_q[0].l);
               chk("tuser", bus.output_axis_tuser, exp_q[0].u);
            end
         end
         if (in_frame && bus.output_axis_tready && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (b.l) begin
               exp_fc++;
               in_frame = 1'b0;
            end
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            for (int k = 0; k <= int'(bus.cmd_len); k++) begin
               d   = bus.cmd_seed + DW'(k);
               b.d = d;
               b.l = (k == int'(bus.cmd_len));
               b.u = bus.cmd_bad && (k == int'(bus.cmd_len));
               exp_q.push_back(b);
            end
            in_frame = 1'b1;
         end
      end
   end

   // Called and returns just after a rising edge.
   task automatic send_cmd(input logic [LW-1:0] len, input logic [DW-1:0] seed, input logic b);
      int n;
      bus.cmd_valid = 1'b1;
      bus.cmd_len   = len;
      bus.cmd_seed  = seed;
      bus.cmd_bad   = b;
      n = 0;
      @(negedge clk);
      while (!bus.cmd_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!bus.cmd_ready) chk("cmd_timeout", 0, 1);
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || bus.output_axis_tvalid) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) chk("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   logic bp_pat [8];
   bit   rand_done;

   initial begin
      rst                    = 1'b1;
      bus.cmd_valid          = 1'b0;
      bus.cmd_len            = '0;
      bus.cmd_seed           = '0;
      bus.cmd_bad            = 1'b0;
      bus.output_axis_tready = 1'b0;
      rand_done              = 1'b0;
      bp_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", bus.output_axis_tvalid, 0);
      chk("rst_tlast", bus.output_axis_tlast, 0);
      chk("rst_tuser", bus.output_axis_tuser, 0);
      chk("rst_tdata", bus.output_axis_tdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      @(posedge clk);
      #1;

      // Reset in the middle of a 6-beat frame, then a clean frame.
      bus.output_axis_tready = 1'b1;
      send_cmd(8'd5, 8'h30, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("midrst_tvalid", bus.output_axis_tvalid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_fc", frame_count, 0);
      @(posedge clk);
      #1;
      send_cmd(8'd2, 8'h55, 1'b0);
      wait_idle();
      chk("after_rst_fc", frame_count, 1);

      send_cmd(8'd3, 8'h10, 1'b0);
      wait_idle();
      chk("single_fc", frame_count, 2);

      send_cmd(8'd2, 8'hFE, 1'b1);
      wait_idle();

      send_cmd(8'd4, 8'h40, 1'b0);
      for (int i = 0; i < 8; i++) begin
         bus.output_axis_tready = bp_pat[i];
         @(posedge clk);
         #1;
      end
      bus.output_axis_tready = 1'b1;
      wait_idle();
      chk("bp_fc", frame_count, 4);

      send_cmd(8'd0, 8'hA0, 1'b0);
      send_cmd(8'd1, 8'hB0, 1'b0);
      wait_idle();
      chk("b2b_fc", frame_count, 6);

      send_cmd(8'd255, 8'h80, 1'b1);
      wait_idle();
      chk("max_fc", frame_count, 7);

      fork
         begin
            for (int i = 0; i < 30; i++) begin
               send_cmd(($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 40))
                                                    : LW'($urandom_range(0, 5)),
                        DW'($urandom), 1'($urandom_range(0, 1)));
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1 bus.output_axis_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      bus.output_axis_tready = 1'b1;
      wait_idle();
      chk("queue_empty", exp_q.size(), 0);
      chk("final_fc", frame_count, 37);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
